uart_rx_fifo: RTL and testbench

Receive buffer sitting directly downstream of the UART receiver. Synchronises the receiver's byte-done flag into the system clock domain and captures exactly one byte per received frame. Stores bytes in a circular FIFO. Presents them to the host side through a read-enable handshake with occupancy and overflow status.

---
 rtl/uart_rx_fifo.sv | 140 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer downstream of the UART receiver.
// Synchronises the receiver done flag and writes one byte per rising edge.
// Bytes are held in a circular FIFO and read out through rd_en/rd_valid.
// Optional build macro UART_RX_FIFO_OVERWRITE_EN: a write into a full FIFO
// replaces the oldest entry instead of dropping the new byte.
module uart_rx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_dout,
  input  logic              rx_done_tick,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Done-flag synchroniser and edge history
  logic sync1_q, sync2_q, prev_q;
  logic wr;

  // FIFO state
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  // Handshake decode
  logic rd_acc;
  logic wr_acc;
  logic ovf_evt;
  logic mem_we;

  // Two-flop synchroniser plus edge history; preset high so a receiver held
  // in reset (done high) never looks like a fresh frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_done_tick;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign wr = sync2_q & ~prev_q;

  assign empty = (count_q == '0);
  assign full  = (count_q == (ADDR_W + 1)'(DEPTH));

  // A read frees a slot in the same cycle, so a full FIFO still accepts the
  // write when a read is accepted alongside it.
  assign rd_acc  = rd_en & ~empty;
  assign wr_acc  = wr & (~full | rd_acc);
  assign ovf_evt = wr & full & ~rd_acc;

  // Next-state for pointers, occupancy and sticky overflow
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    mem_we     = 1'b0;
    overflow_d = overflow_q;

    if (rd_acc) begin
      rptr_d = rptr_q + ADDR_W'(1);
    end
    if (wr_acc) begin
      mem_we = 1'b1;
      wptr_d = wptr_q + ADDR_W'(1);
    end
`ifdef UART_RX_FIFO_OVERWRITE_EN
    if (ovf_evt) begin
      mem_we = 1'b1;
      wptr_d = wptr_q + ADDR_W'(1);
      rptr_d = rptr_q + ADDR_W'(1);
    end
`endif

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    // A new overflow in the same cycle as a clear takes priority
    if (ovf_evt) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Storage array; contents survive reset and are simply orphaned by it
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wptr_q] <= rx_dout;
    end
  end

  // Pointer, occupancy, status and registered read-port state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_data_q <= mem_q[rptr_q];
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo.
// Honours UART_RX_FIFO_OVERWRITE_EN for the full-FIFO expectations.
module tb_uart_rx_fifo;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] rx_dout;
  logic              rx_done_tick;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              ovf_clr;

  int unsigned errs   = 0;
  int unsigned checks = 0;

  uart_rx_fifo #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_dout     (rx_dout),
    .rx_done_tick(rx_done_tick),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full frame: done high for 8 clocks, then low long enough to re-arm
  task automatic send(input logic [7:0] b);
    rx_dout      = b;
    rx_done_tick = 1'b1;
    cyc(8);
    rx_done_tick = 1'b0;
    cyc(4);
  endtask

  // Raise done and hold rd_en / ovf_clr during the clock that performs the
  // write (third rising edge after the raise); returns one negedge later.
  task automatic send_sync(input logic [7:0] b, input logic do_rd, input logic do_clr);
    rx_dout      = b;
    rx_done_tick = 1'b1;
    cyc(2);
    rd_en   = do_rd;
    ovf_clr = do_clr;
    cyc(1);
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic finish_frame();
    cyc(5);
    rx_done_tick = 1'b0;
    cyc(4);
  endtask

  task automatic do_read(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    chk({tag, "_valid"}, rd_valid, 1);
    chk({tag, "_data"}, rd_data, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] e;
    reset        = 1'b0;
    rx_dout      = '0;
    rx_done_tick = 1'b0;
    rd_en        = 1'b0;
    ovf_clr      = 1'b0;
    cyc(3);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_rdd", rd_data, 0);
    reset = 1'b1;
    cyc(3);

    // 1: single frame, single read
    send(8'hA5);
    chk("t1_count", count, 1);
    chk("t1_empty", empty, 0);
    do_read("t1_rd", 8'hA5);
    chk("t1_count0", count, 0);
    chk("t1_empty1", empty, 1);
    cyc(1);
    chk("t1_rdv_pulse", rd_valid, 0);

    // 2: reset while done is already high must not produce a write
    rx_done_tick = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(3);
    chk("t2_rst_count", count, 0);
    reset = 1'b1;
    cyc(6);
    chk("t2_nowrite", count, 0);
    rx_done_tick = 1'b0;
    cyc(4);
    send(8'h3C);
    chk("t2_count", count, 1);
    do_read("t2_rd", 8'h3C);

    // 3: fill, overflow, drain in order
    for (int i = 0; i < 16; i++) send(8'(i));
    chk("t3_full", full, 1);
    chk("t3_count16", count, 16);
    send(8'h10);
    chk("t3_ovf", overflow, 1);
    chk("t3_count_ovf", count, 16);
    for (int i = 0; i < 16; i++) begin
`ifdef UART_RX_FIFO_OVERWRITE_EN
      e = 8'(i + 1);
`else
      e = 8'(i);
`endif
      do_read("t3_rd", e);
    end
    chk("t3_empty", empty, 1);
    chk("t3_ovf_hold", overflow, 1);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", overflow, 0);

    // 4: full FIFO, write and read in the same cycle
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i));
    chk("t4_full", full, 1);
    send_sync(8'h30, 1'b1, 1'b0);
    chk("t4_rdv", rd_valid, 1);
    chk("t4_rdd", rd_data, 8'h20);
    chk("t4_count", count, 16);
    chk("t4_ovf", overflow, 0);
    finish_frame();
    for (int i = 1; i < 16; i++) do_read("t4_rd", 8'(8'h20 + i));
    do_read("t4_rd_last", 8'h30);
    chk("t4_empty", empty, 1);

    // 5: empty FIFO read+write, then overflow racing ovf_clr
    send_sync(8'h77, 1'b1, 1'b0);
    chk("t5_rdv", rd_valid, 0);
    chk("t5_count", count, 1);
    finish_frame();
    for (int i = 0; i < 15; i++) send(8'(8'h80 + i));
    chk("t5_full", full, 1);
    send_sync(8'hEE, 1'b0, 1'b1);
    chk("t5_set_wins", overflow, 1);
    chk("t5_count_ovf", count, 16);
    finish_frame();
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("t5_clr", overflow, 0);
`ifdef UART_RX_FIFO_OVERWRITE_EN
    for (int i = 0; i < 15; i++) do_read("t5_rd", 8'(8'h80 + i));
    do_read("t5_rd_last", 8'hEE);
    e = 8'hEE;
`else
    do_read("t5_rd_first", 8'h77);
    for (int i = 0; i < 15; i++) do_read("t5_rd", 8'(8'h80 + i));
    e = 8'h8E;
`endif
    chk("t5_empty", empty, 1);
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    chk("t5_rd_empty_v", rd_valid, 0);
    chk("t5_rd_empty_d", rd_data, e);
    chk("t5_rd_empty_c", count, 0);

    // 6: wrap with interleaved write/read pairs
    for (int i = 0; i < 40; i++) begin
      send(8'(i) ^ 8'h5A);
      do_read("t6_rd", 8'(i) ^ 8'h5A);
    end
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_ovf", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
